// File: rtl/olimp_pkg.sv
// Shared definitions for the olimp vector-MAC sequencer: FSM states and datapath widths.
package olimp_pkg;

  localparam int DATA_W      = 64;
  localparam int COEF_W      = 128;
  localparam int ACC_W       = 32;
  localparam int MAC_LATENCY = 3;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } state_e;

endpackage

// File: rtl/olimp_vec_seq_if.sv
// Command and result handshakes of olimp_vec_seq, bundled for the requester (master) and sequencer (slave).
interface olimp_vec_seq_if
  import olimp_pkg::*;
#(
  parameter int LEN_W  = 8,
  parameter int ADDR_W = 8
) ();

  logic              cmd_valid;
  logic              cmd_ready;
  logic [LEN_W-1:0]  cmd_len;
  logic [ADDR_W-1:0] cmd_daddr;
  logic [ADDR_W-1:0] cmd_caddr;
  logic              res_valid;
  logic              res_ready;
  logic [ACC_W-1:0]  res_acc0;
  logic [ACC_W-1:0]  res_acc1;

  modport master (
    output cmd_valid, cmd_len, cmd_daddr, cmd_caddr, res_ready,
    input  cmd_ready, res_valid, res_acc0, res_acc1
  );

  modport slave (
    input  cmd_valid, cmd_len, cmd_daddr, cmd_caddr, res_ready,
    output cmd_ready, res_valid, res_acc0, res_acc1
  );

endinterface

// File: rtl/olimp_tag_pipe.sv
// Valid-tag shift register that follows each read step through memory and MAC latency.
module olimp_tag_pipe #(
  parameter int DEPTH = 4
) (
  input  logic clk_dsp,
  input  logic rst_n,
  input  logic tag_in,
  output logic tag_out,
  output logic tag_pending
);

  localparam logic [DEPTH-1:0] OTHERS_MASK = ~(DEPTH'(1) << (DEPTH - 1));

  logic [DEPTH-1:0] tags;

  // NOTE: sequential state uses non-blocking assignments so every stage samples its predecessor's pre-edge value.
  always_ff @(posedge clk_dsp or negedge rst_n) begin
    if (!rst_n) begin
      tags <= '0;
    end else begin
      tags[0] <= tag_in;
      for (int i = 1; i < DEPTH; i++) begin
        tags[i] <= tags[i-1];
      end
    end
  end

  assign tag_out     = tags[DEPTH-1];
  // Any tag still travelling behind the one at the exit.
  assign tag_pending = |(tags & OTHERS_MASK);

endmodule

// File: rtl/olimp_vec_seq.sv
// Streams cmd_len operand pairs from data/coef memories to an external vector MAC and accumulates its lane sums.
module olimp_vec_seq
  import olimp_pkg::*;
#(
  parameter int LATENCY = MAC_LATENCY,
  parameter int LEN_W   = 8,
  parameter int ADDR_W  = 8
) (
  input  logic               clk_dsp,
  input  logic               rst_n,
  olimp_vec_seq_if.slave     bus,
  output logic               mem_rd,
  output logic [ADDR_W-1:0]  data_addr,
  output logic [ADDR_W-1:0]  coef_addr,
  input  logic [DATA_W-1:0]  data_rdata,
  input  logic [COEF_W-1:0]  coef_rdata,
  output logic [DATA_W-1:0]  mac_data,
  output logic [COEF_W-1:0]  mac_coef,
  input  logic [ACC_W-1:0]   mac_acc0,
  input  logic [ACC_W-1:0]   mac_acc1,
  output logic               busy
);

  state_e            state, state_nxt;
  logic [LEN_W-1:0]  cnt;
  logic [ACC_W-1:0]  acc0, acc1;
  logic              ready_en;
  logic              accept;
  logic              tag_out, tag_pending;

  assign mac_data = data_rdata;
  assign mac_coef = coef_rdata;

  assign accept        = bus.cmd_valid & bus.cmd_ready;
  assign bus.res_acc0  = acc0;
  assign bus.res_acc1  = acc1;

  olimp_tag_pipe #(
    .DEPTH(LATENCY + 1)
  ) u_tag_pipe (
    .clk_dsp     (clk_dsp),
    .rst_n       (rst_n),
    .tag_in      (mem_rd),
    .tag_out     (tag_out),
    .tag_pending (tag_pending)
  );

  always_ff @(posedge clk_dsp or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: every output of this block gets a default first, so no path leaves a value held and no latch is inferred.
  always_comb begin
    state_nxt     = state;
    bus.cmd_ready = 1'b0;
    bus.res_valid = 1'b0;
    mem_rd        = 1'b0;
    busy          = 1'b1;
    unique case (state)
      IDLE: begin
        busy          = 1'b0;
        bus.cmd_ready = ready_en;
        if (accept) state_nxt = (bus.cmd_len == '0) ? DONE : ISSUE;
      end
      ISSUE: begin
        mem_rd = 1'b1;
        if (cnt == LEN_W'(1)) state_nxt = DRAIN;
      end
      DRAIN: begin
        // Leave on the edge that absorbs the final step's result.
        if (tag_out && !tag_pending) state_nxt = DONE;
      end
      DONE: begin
        bus.res_valid = 1'b1;
        if (bus.res_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Holds cmd_ready low until the first edge after reset release.
  always_ff @(posedge clk_dsp or negedge rst_n) begin
    if (!rst_n) ready_en <= 1'b0;
    else        ready_en <= 1'b1;
  end

  always_ff @(posedge clk_dsp or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      data_addr <= '0;
      coef_addr <= '0;
      acc0      <= '0;
      acc1      <= '0;
    end else if (accept) begin
      cnt       <= bus.cmd_len;
      data_addr <= bus.cmd_daddr;
      coef_addr <= bus.cmd_caddr;
      acc0      <= '0;
      acc1      <= '0;
    end else begin
      if (mem_rd) begin
        cnt       <= cnt - LEN_W'(1);
        data_addr <= data_addr + ADDR_W'(1);
        coef_addr <= coef_addr + ADDR_W'(1);
      end
      // Only tagged MAC results reach the accumulators; the MAC runs free otherwise.
      if (tag_out) begin
        acc0 <= acc0 + mac_acc0;
        acc1 <= acc1 + mac_acc1;
      end
    end
  end

endmodule

// File: tb/tb_olimp_vec_seq.sv
// Self-checking bench for olimp_vec_seq: memory and MAC models, directed vector table, corner sequences, random commands.
module tb_olimp_vec_seq;

  localparam int LAT = 3;

  logic          clk_dsp = 1'b0;
  logic          rst_n   = 1'b1;
  logic          mem_rd;
  logic [7:0]    data_addr, coef_addr;
  logic [63:0]   data_rdata;
  logic [127:0]  coef_rdata;
  logic [63:0]   mac_data;
  logic [127:0]  mac_coef;
  logic [31:0]   mac_acc0, mac_acc1;
  logic          busy;

  int n_checks = 0;
  int n_fail   = 0;

  olimp_vec_seq_if #(.LEN_W(8), .ADDR_W(8)) bus ();

  olimp_vec_seq #(.LATENCY(LAT), .LEN_W(8), .ADDR_W(8)) dut (
    .clk_dsp    (clk_dsp),
    .rst_n      (rst_n),
    .bus        (bus),
    .mem_rd     (mem_rd),
    .data_addr  (data_addr),
    .coef_addr  (coef_addr),
    .data_rdata (data_rdata),
    .coef_rdata (coef_rdata),
    .mac_data   (mac_data),
    .mac_coef   (mac_coef),
    .mac_acc0   (mac_acc0),
    .mac_acc1   (mac_acc1),
    .busy       (busy)
  );

  always #5 clk_dsp = ~clk_dsp;

  // Memories: 1-cycle synchronous read; junk on the bus whenever no read was issued.
  logic [63:0]  data_mem [256];
  logic [127:0] coef_mem [256];

  always @(posedge clk_dsp) begin
    if (mem_rd) begin
      data_rdata <= data_mem[data_addr];
      coef_rdata <= coef_mem[coef_addr];
    end else begin
      data_rdata <= {$urandom, $urandom};
      coef_rdata <= {$urandom, $urandom, $urandom, $urandom};
    end
  end

  // Signed 8-lane byte dot product.
  function automatic logic [31:0] dot8(input logic [63:0] d, input logic [63:0] c);
    int s = 0;
    for (int i = 0; i < 8; i++) begin
      int a = $signed(d[i*8 +: 8]);
      int b = $signed(c[i*8 +: 8]);
      s += a * b;
    end
    return s;
  endfunction

  // Free-running external MAC with LAT cycles from operand sample to result.
  logic [31:0] p0 [LAT];
  logic [31:0] p1 [LAT];
  always @(posedge clk_dsp) begin
    p0[0] <= dot8(mac_data, mac_coef[63:0]);
    p1[0] <= dot8(mac_data, mac_coef[127:64]);
    for (int i = 1; i < LAT; i++) begin
      p0[i] <= p0[i-1];
      p1[i] <= p1[i-1];
    end
  end
  assign mac_acc0 = p0[LAT-1];
  assign mac_acc1 = p1[LAT-1];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // Reference: sum over steps of lane dot products, addresses wrapping mod 256.
  function automatic logic [31:0] ref_sum(input int len, input logic [7:0] da, input logic [7:0] ca,
                                          input int lane);
    logic [31:0] s = '0;
    for (int k = 0; k < len; k++) begin
      logic [7:0] a = da + 8'(k);
      logic [7:0] b = ca + 8'(k);
      s += (lane == 0) ? dot8(data_mem[a], coef_mem[b][63:0]) : dot8(data_mem[a], coef_mem[b][127:64]);
    end
    return s;
  endfunction

  task automatic fill(input int len, input logic [7:0] da, input logic [7:0] ca,
                      input logic [7:0] db, input logic [7:0] cb);
    for (int k = 0; k < len; k++) begin
      logic [7:0] a = da + 8'(k);
      logic [7:0] b = ca + 8'(k);
      data_mem[a] = {8{db}};
      coef_mem[b] = {16{cb}};
    end
  endtask

  task automatic send_cmd(input string nm, input int len, input logic [7:0] da, input logic [7:0] ca,
                          output bit ok);
    @(negedge clk_dsp);
    bus.cmd_valid = 1'b1;
    bus.cmd_len   = 8'(len);
    bus.cmd_daddr = da;
    bus.cmd_caddr = ca;
    for (int w = 0; w < 20 && !bus.cmd_ready; w++) @(negedge clk_dsp);
    ok = bus.cmd_ready;
    if (!ok) begin
      check({nm, " cmd_ready_timeout"}, 0, 1);
      bus.cmd_valid = 1'b0;
      return;
    end
    @(posedge clk_dsp);
    @(negedge clk_dsp);
    bus.cmd_valid = 1'b0;
  endtask

  // Runs one command; t counts cycles from the first cycle after acceptance.
  task automatic run_cmd(input string nm, input int len, input logic [7:0] da, input logic [7:0] ca,
                         input int rdy_dly, input logic [31:0] e0, input logic [31:0] e1, input int elat);
    int t = 0, rd_cnt = 0, addr_err = 0, stab_err = 0;
    logic [7:0] ea_d = da, ea_c = ca;
    bit seen = 0, ok;
    send_cmd(nm, len, da, ca, ok);
    if (!ok) return;
    while (t < 300) begin
      if (mem_rd) begin
        rd_cnt++;
        if (data_addr !== ea_d || coef_addr !== ea_c || t >= len) addr_err++;
        ea_d++;
        ea_c++;
      end
      if (bus.res_valid) begin
        seen = 1;
        break;
      end
      t++;
      @(negedge clk_dsp);
    end
    check({nm, " res_valid_seen"}, 64'(seen), 1);
    if (!seen) return;
    check({nm, " latency"},      64'(t), 64'(elat));
    check({nm, " mem_rd_cycles"}, 64'(rd_cnt), 64'(len));
    check({nm, " addr_errs"},    64'(addr_err), 0);
    check({nm, " acc0"},         bus.res_acc0, e0);
    check({nm, " acc1"},         bus.res_acc1, e1);
    for (int d = 0; d < rdy_dly; d++) begin
      @(negedge clk_dsp);
      if (bus.res_valid !== 1'b1 || bus.res_acc0 !== e0 || bus.res_acc1 !== e1 || bus.cmd_ready !== 1'b0)
        stab_err++;
    end
    if (rdy_dly > 0) check({nm, " backpressure_stable_errs"}, 64'(stab_err), 0);
    bus.res_ready = 1'b1;
    @(negedge clk_dsp);
    bus.res_ready = 1'b0;
    check({nm, " idle_after_ready"}, {bus.cmd_ready, bus.res_valid, busy}, 3'b100);
  endtask

  typedef struct {
    string      name;
    int         len;
    logic [7:0] da, ca, db, cb;
    logic [31:0] e0, e1;
    int         elat;
  } vec_t;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    vec_t vecs[6];
    bit   ok;

    bus.cmd_valid = 1'b0;
    bus.cmd_len   = '0;
    bus.cmd_daddr = '0;
    bus.cmd_caddr = '0;
    bus.res_ready = 1'b0;
    for (int i = 0; i < 256; i++) begin
      data_mem[i] = '0;
      coef_mem[i] = '0;
    end

    // Reset behaviour.
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk_dsp);
    check("rst outputs {mem_rd,res_valid,busy,cmd_ready}",
          {mem_rd, bus.res_valid, busy, bus.cmd_ready}, 4'b0000);
    check("rst res_acc", {bus.res_acc0, bus.res_acc1}, 64'd0);
    rst_n = 1'b1;
    #1 check("cmd_ready before first edge", 64'(bus.cmd_ready), 0);
    @(posedge clk_dsp);
    #1 check("cmd_ready after first edge", 64'(bus.cmd_ready), 1);

    vecs[0] = '{"v_len1",      1, 8'h10, 8'h20, 8'h01, 8'h02, 32'd16,       32'd16,       5};
    vecs[1] = '{"v_len4_7f",   4, 8'h30, 8'h40, 8'h7F, 8'h7F, 32'd516128,   32'd516128,   8};
    vecs[2] = '{"v_len2_neg",  2, 8'h50, 8'h60, 8'h80, 8'h7F, 32'hFFFC0800, 32'hFFFC0800, 6};
    vecs[3] = '{"v_len0",      0, 8'h70, 8'h80, 8'h55, 8'h55, 32'd0,        32'd0,        0};
    vecs[4] = '{"v_wrap",      2, 8'hFF, 8'h10, 8'h03, 8'h05, 32'd240,      32'd240,      6};
    vecs[5] = '{"v_backpress", 1, 8'h10, 8'h20, 8'h01, 8'h02, 32'd16,       32'd16,       5};

    for (int i = 0; i < 6; i++) begin
      fill(vecs[i].len, vecs[i].da, vecs[i].ca, vecs[i].db, vecs[i].cb);
      run_cmd(vecs[i].name, vecs[i].len, vecs[i].da, vecs[i].ca, (i == 5) ? 10 : 1,
              vecs[i].e0, vecs[i].e1, vecs[i].elat);
    end

    // Reset during step 2 of a len=4 command, then a clean len=1 command right after.
    fill(4, 8'h90, 8'hA0, 8'h7F, 8'h7F);
    fill(1, 8'hC0, 8'hD0, 8'h01, 8'h02);
    send_cmd("rst_mid", 4, 8'h90, 8'hA0, ok);
    if (ok) begin
      repeat (2) @(negedge clk_dsp);
      check("rst_mid issuing before reset", 64'(mem_rd), 1);
      rst_n = 1'b0;
      #1;
      check("rst_mid outputs {mem_rd,res_valid,busy,cmd_ready}",
            {mem_rd, bus.res_valid, busy, bus.cmd_ready}, 4'b0000);
      check("rst_mid res_acc", {bus.res_acc0, bus.res_acc1}, 64'd0);
      #2 rst_n = 1'b1;
      @(posedge clk_dsp);
      #1 check("rst_mid cmd_ready after release", 64'(bus.cmd_ready), 1);
      run_cmd("rst_mid_next", 1, 8'hC0, 8'hD0, 0, 32'd16, 32'd16, 5);
    end

    // Random commands against the reference sum.
    for (int i = 0; i < 256; i++) begin
      data_mem[i] = {$urandom, $urandom};
      coef_mem[i] = {$urandom, $urandom, $urandom, $urandom};
    end
    for (int r = 0; r < 25; r++) begin
      int         len = $urandom_range(0, 16);
      logic [7:0] da  = 8'($urandom);
      logic [7:0] ca  = 8'($urandom);
      run_cmd($sformatf("rand%0d", r), len, da, ca, $urandom_range(0, 3),
              ref_sum(len, da, ca, 0), ref_sum(len, da, ca, 1), (len > 0) ? len + LAT + 1 : 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/olimp_vec_seq.md
OLIMP_VEC_SEQ -- requirements
Module: olimp_vec_seq

Interface
REQ-001 SHALL have parameter LATENCY, default 3: MAC pipeline depth in clk_dsp cycles, from operands sampled to mac_acc0/1 valid.
REQ-002 SHALL have parameter LEN_W, default 8: width of the step count.
REQ-003 SHALL have parameter ADDR_W, default 8: width of the operand memory addresses.
REQ-004 clk_dsp  in  1  sole clock, rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 cmd_valid/cmd_ready  in/out  1/1  command handshake.
REQ-007 cmd_len  in  LEN_W  number of 64/128-bit steps to accumulate.
REQ-008 cmd_daddr/cmd_caddr  in  ADDR_W  start addresses of the data and coef memories.
REQ-009 mem_rd  out  1  read strobe shared by both memories; each has 1-cycle synchronous read.
REQ-010 data_addr/coef_addr  out  ADDR_W  read addresses.
REQ-011 data_rdata/coef_rdata  in  64/128  read data, valid the cycle after mem_rd.
REQ-012 mac_data/mac_coef  out  64/128  operands to the external vector MAC; equal data_rdata/coef_rdata.
REQ-013 mac_acc0/mac_acc1  in  32/32  per-lane dot products from the MAC.
REQ-014 res_valid/res_ready  out/in  1/1  result handshake.
REQ-015 res_acc0/res_acc1  out  32/32  accumulated lane sums.
REQ-016 busy  out  1  high in every state except IDLE.

Function
REQ-017 States SHALL be IDLE, ISSUE, DRAIN, DONE.
REQ-018 cmd_ready SHALL be high only in IDLE; acceptance = cmd_valid & cmd_ready at a rising edge.
REQ-019 On acceptance with cmd_len>0: load addresses and count, clear both accumulators, go to ISSUE.
REQ-020 On acceptance with cmd_len=0: clear accumulators, go directly to DONE; no mem_rd is issued.
REQ-021 In ISSUE, mem_rd SHALL be high for exactly cmd_len consecutive cycles; addresses +1 per step, wrapping modulo 2^ADDR_W.
REQ-022 A valid tag SHALL travel with each step through a LATENCY+1 deep shift register (1 memory + LATENCY MAC).
REQ-023 When a tag exits, the step's mac_acc0/mac_acc1 SHALL be added into acc0/acc1 on that edge, two's complement, wrapping modulo 2^32.
REQ-024 Timing: if the first ISSUE cycle is C, step k accumulates on the edge ending cycle C+k+1+LATENCY.
REQ-025 After the last mem_rd, ISSUE SHALL go to DRAIN; DRAIN SHALL go to DONE on the edge of the last accumulation.
REQ-026 res_valid SHALL be high in DONE only: from cycle C+N+LATENCY+1 for N>0, and from the cycle after acceptance for N=0.
REQ-027 res_acc0/1 SHALL be stable while res_valid & !res_ready.
REQ-028 DONE SHALL go to IDLE on res_valid & res_ready; a new command is accepted no earlier than the next cycle.
REQ-029 Untagged MAC outputs SHALL never be accumulated.

Reset
REQ-030 rst_n low SHALL force asynchronously: state IDLE, all tags 0, accumulators 0, counters/addresses 0.
REQ-031 During reset, outputs SHALL be: mem_rd=0, res_valid=0, busy=0, res_acc0/1=0; cmd_ready SHALL rise on the first edge after rst_n deasserts.
REQ-032 Reset mid-operation SHALL abandon the command; in-flight MAC results SHALL be discarded.

Structure
REQ-033 Shared package olimp_pkg SHALL hold the state enum and constants DATA_W=64, COEF_W=128, ACC_W=32, and MAC_LATENCY=3.
REQ-034 The valid-tag shift register SHALL be one sub-module, olimp_tag_pipe, parameterised by depth.
REQ-035 The MAC SHALL not be instantiated inside; it connects via the mac_* ports.

Verification
REQ-036 len=1, data bytes 0x01, coef bytes 0x02 -> res_acc0=res_acc1=16, res_valid at C+5.
REQ-037 len=4, all bytes 0x7F -> res_acc0=res_acc1=516128, one mem_rd pulse train of 4 cycles, res_valid at C+8.
REQ-038 len=2, data 0x80, coef 0x7F -> res_acc0=res_acc1=0xFFFC0800 (-260096).
REQ-039 len=0 -> res_valid the cycle after acceptance, results 0, mem_rd never high; daddr=0xFF with len=2 -> data_addr 0xFF then 0x00.
REQ-040 res_ready low for 10 cycles in DONE -> res_valid and results stable, cmd_ready low, then IDLE one cycle after res_ready.
REQ-041 rst_n pulsed low during step 2 of len=4 -> outputs reset immediately; next len=1 command yields 16 per REQ-036 with no stale contribution.
